// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers of the MIPS32 core:
// stage state encoding, the canonical NOP instruction word and the default
// performance counter width.
package pipe_pkg;

  typedef logic [1:0] pipe_state_t;

  // Legacy-compatible state encoding.
  localparam pipe_state_t PIPE_ST_EMPTY = 2'b00;
  localparam pipe_state_t PIPE_ST_FULL  = 2'b01;
  localparam pipe_state_t PIPE_ST_SKID  = 2'b10;

  // sll $0,$0,0 -- all-zero instruction word.
  localparam logic [31:0] PIPE_NOP_INSTR = 32'h0000_0000;

  localparam int unsigned PIPE_CNT_W_DEFAULT = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for stage performance statistics.
// Cleared only by reset; holds at all-ones instead of wrapping.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count qualifying cycles, stop at the maximum value.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake,
// flush-to-NOP and a 2-entry skid buffer. in_ready, out_valid and out_data
// all come straight from flops, so downstream stalls never form a
// combinational ready path back up the pipe.
// Optional feature macro: PIPE_PERF_CNT_EN enables the stall/bubble
// saturating counters; without it both counter ports read zero.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W  = 32,
  parameter logic [DATA_W-1:0]  NOP_VAL = '0,
  parameter int unsigned        CNT_W   = PIPE_CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_state_t       state;
  logic              main_v;
  logic              skid_v;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_d;
  logic              in_fire;
  logic              out_fire;

  assign in_fire   = in_valid & ~skid_v;
  assign out_fire  = main_v & out_ready;

  assign out_data  = main_d;
  assign out_valid = main_v;
  assign in_ready  = ~skid_v;

  // The valid flags are kept as dedicated flops alongside the state code so
  // the handshake outputs never pass through a state decode.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state  <= PIPE_ST_EMPTY;
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= NOP_VAL;
      skid_d <= NOP_VAL;
    end else begin
      case (state)
        PIPE_ST_EMPTY: begin
          if (in_fire) begin
            main_d <= in_data;
            main_v <= 1'b1;
            state  <= PIPE_ST_FULL;
          end
        end
        PIPE_ST_FULL: begin
          if (in_fire && out_fire) begin
            main_d <= in_data;
          end else if (in_fire) begin
            skid_d <= in_data;
            skid_v <= 1'b1;
            state  <= PIPE_ST_SKID;
          end else if (out_fire) begin
            main_v <= 1'b0;
            state  <= PIPE_ST_EMPTY;
          end
        end
        PIPE_ST_SKID: begin
          if (out_fire) begin
            main_d <= skid_d;
            skid_v <= 1'b0;
            state  <= PIPE_ST_FULL;
          end
        end
        default: begin
          state  <= PIPE_ST_EMPTY;
          main_v <= 1'b0;
          skid_v <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic stall_inc;
  logic bubble_inc;

  assign stall_inc  = main_v & ~out_ready;
  assign bubble_inc = ~main_v;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bubble_inc),
    .cnt   (bubble_cnt)
  );
`else
  assign stall_cnt  = {CNT_W{1'b0}};
  assign bubble_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: stimulus pushes accepted payloads
// into an ordered queue, a monitor checks the DUT against that queue (capacity
// two, head is presented, flush/reset empty it) and against counter models.
module tb_pipe_stage_skid_reg;

  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 4;
  localparam logic [DW-1:0] NOP = '0;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;

  pipe_stage_skid_reg #(
    .DATA_W  (DW),
    .NOP_VAL (NOP),
    .CNT_W   (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  int            vectors = 0;
  int            miscompares = 0;
  bit            started = 0;
  logic [DW-1:0] idle_exp = NOP;
  int unsigned   stall_m = 0;
  int unsigned   bubble_m = 0;
  localparam int unsigned CMAX = (1 << CW) - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT state with the reference queue each cycle.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (started) begin
        check("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
        check("in_ready",  {31'b0, in_ready},  {31'b0, q.size() < 2});
        check("out_data",  out_data, (q.size() != 0) ? q[0] : idle_exp);
`ifdef PIPE_PERF_CNT_EN
        check("stall_cnt",  {28'b0, stall_cnt},  stall_m);
        check("bubble_cnt", {28'b0, bubble_cnt}, bubble_m);
`else
        check("stall_cnt",  {28'b0, stall_cnt},  32'd0);
        check("bubble_cnt", {28'b0, bubble_cnt}, 32'd0);
`endif
      end
      if (reset) begin
        q.delete();
        idle_exp = NOP;
        stall_m  = 0;
        bubble_m = 0;
        started  = 1;
      end else if (started) begin
        if (q.size() != 0 && !out_ready && stall_m < CMAX) stall_m++;
        if (q.size() == 0 && bubble_m < CMAX) bubble_m++;
        if (q.size() != 0 && out_ready) idle_exp = q.pop_front();
        if (flush) begin
          q.delete();
          idle_exp = NOP;
        end
      end
    end
  end

  // Drive one cycle of inputs; record an acceptance after the monitor ran.
  task automatic drive(input bit iv, input logic [DW-1:0] id, input bit ordy,
                       input bit fl, input bit rst);
    bit acc;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    acc = iv && (in_ready === 1'b1) && !fl && !rst;
    #3;
    if (acc) q.push_back(id);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;
    // Reset while a payload is offered: it must never appear.
    drive(1, 32'hDEAD_BEEF, 0, 0, 1);
    drive(1, 32'hDEAD_BEEF, 0, 0, 1);
    drive(0, '0, 1, 0, 0);
    drive(0, '0, 1, 0, 0);
    // Streaming 1..8 at full rate.
    for (int i = 1; i <= 8; i++) drive(1, i, 1, 0, 0);
    drive(0, '0, 1, 0, 0);
    drive(0, '0, 1, 0, 0);
    // Backpressure: 5 in main, 6 into skid, 7 held off, then drain.
    drive(1, 5, 1, 0, 0);
    drive(1, 6, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 7, 0, 0, 0);
    drive(1, 7, 1, 0, 0);
    drive(1, 7, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, '0, 1, 0, 0);
    // Flush while in SKID (main=5, skid=6) with 9 offered.
    drive(1, 5, 1, 0, 0);
    drive(1, 6, 0, 0, 0);
    drive(1, 9, 0, 1, 0);
    drive(0, '0, 1, 0, 0);
    drive(0, '0, 1, 0, 0);
    // 100 cycles of simultaneous in_fire/out_fire.
    for (int i = 0; i < 100; i++) drive(1, $urandom, 1, 0, 0);
    drive(0, '0, 1, 0, 0);
    // 20 stall cycles for counter saturation, then flush, then reset.
    drive(1, 32'h1234, 1, 0, 0);
    for (int i = 0; i < 20; i++) drive(0, '0, 0, 0, 0);
    drive(0, '0, 0, 1, 0);
    drive(0, '0, 0, 0, 0);
    drive(0, '0, 0, 0, 1);
    drive(0, '0, 1, 0, 0);
    drive(0, '0, 1, 0, 0);
    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      drive(bit'($urandom_range(0, 3) != 0), $urandom, bit'($urandom_range(0, 9) < 7),
            bit'($urandom_range(0, 99) < 3), bit'($urandom_range(0, 99) < 1));
    end
    for (int i = 0; i < 4; i++) drive(0, '0, 1, 0, 0);
    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the 5-stage MIPS32 core. Replaces the fixed per-stage registers (F/D, D/E, E/M, M/W).
- Adds a valid/ready handshake, flush-to-NOP, and a 2-entry skid buffer, so a downstream stall never creates a combinational ready path back up the pipe.
- Payload is one flat vector. Each stage packs its own fields into it (e.g. ALU result, memory read data, CP0 data, A3, PC+8, instruction).

Parameters:
- DATA_W, 32, payload width in bits; legal range 1 to 512.
- NOP_VAL, {DATA_W{1'b0}}, value loaded into the output register on reset and on flush. All-zero gives instr sll $0,$0,0 and A3=0.
- CNT_W, 16, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- flush  in  1  kill all held entries (exception or branch squash); synchronous.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage can accept; driven directly from a register.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a live entry; driven directly from a register.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  DATA_W  payload to the next stage; driven directly from the main register.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.
- bubble_cnt  out  CNT_W  cycles with out_valid=0.

Behaviour:
- Handshake terms: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (main_d, main_v) and skid register (skid_d, skid_v).
- Output mapping: out_data = main_d, out_valid = main_v, in_ready = !skid_v.
- States: EMPTY (main_v=0, skid_v=0), FULL (main_v=1, skid_v=0), SKID (both valid).
- EMPTY:
  - in_fire: main_d <= in_data, go to FULL.
  - otherwise: hold.
- FULL:
  - in_fire & out_fire: main_d <= in_data, stay FULL.
  - in_fire & !out_fire: skid_d <= in_data, go to SKID.
  - !in_fire & out_fire: go to EMPTY; main_d keeps its old value.
  - neither: hold.
- SKID:
  - in_ready=0, so no new input is accepted.
  - out_fire: main_d <= skid_d, go to FULL.
  - otherwise: hold.
- Timing:
  - Latency is 1 cycle from in_fire to out_valid.
  - Sustained throughput is 1 transfer per cycle when out_ready stays high.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid must not change.
- Ordering: entries leave in acceptance order; no loss and no duplication.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.
- Priority: reset > flush > normal operation.
- Reset and flush action (next edge): main_v=0, skid_v=0, main_d=NOP_VAL, skid_d=NOP_VAL, in_ready=1.
  - An in_valid offered in the same cycle as flush is discarded.
  - An out_fire in the same cycle as flush still counts as consumed downstream.
- Reset values:
  - out_valid=0, out_data=NOP_VAL, in_ready=1.
  - stall_cnt=0 and bubble_cnt=0.
- Reset asserted mid-transfer, in any state, drops all entries without exception.

Optional Feature:
- Macro name: PIPE_PERF_CNT_EN.
- When defined:
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - bubble_cnt increments each cycle with !out_valid.
  - Both saturate at all-ones and never wrap.
  - Both are cleared by reset only; flush does not clear them.
- When undefined: both ports are tied to 0, no counter flops are generated, and the port list is unchanged.

Decomposition:
- Shared package pipe_pkg:
  - State encoding: PIPE_ST_EMPTY=2'b00, PIPE_ST_FULL=2'b01, PIPE_ST_SKID=2'b10.
  - Constant PIPE_NOP_INSTR=32'h0000_0000.
  - Default CNT_W.
- Sub-module pipe_sat_counter (parameter CNT_W; ports clk, reset, inc, cnt): instantiated twice under PIPE_PERF_CNT_EN.

Test Plan:
- Reset with in_valid=1, in_data=32'hDEAD_BEEF → after release, out_valid=0, out_data=0, in_ready=1; the offered data never appears.
- Streaming: out_ready=1, in_data=1..8 on consecutive cycles → out_data=1..8 on the next consecutive cycles, out_valid=1 throughout, in_ready never drops.
- Backpressure: after data 5 is accepted, out_ready=0 and offer 6 and 7 → 6 goes into skid, in_ready=0, 7 is held off, out_data=5 stays stable. Then out_ready=1 → outputs 5, 6, 7 in order.
- Flush in SKID state (main=5, skid=6) with in_valid=1, in_data=9 → next cycle out_valid=0, out_data=NOP_VAL, in_ready=1; values 6 and 9 never appear.
- Simultaneous events in FULL with in_fire and out_fire every cycle for 100 cycles → stays in FULL, no bubbles, skid_v stays 0.
- PIPE_PERF_CNT_EN with CNT_W=4, 20 stall cycles → stall_cnt saturates at 15. A following flush leaves it at 15; reset clears it to 0.
